// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional MULDIV_EARLY_OUT_EN: shortcut for zero divisor or zero multiply operand.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          fun3_reg;
  logic [XLEN-1:0]     mag_a_reg, mag_b_reg;
  logic                neg_a_reg, neg_b_reg, b_zero_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     result_reg;

  logic                accept, last_iter, step_en, early_hit;
  logic                signed_a, signed_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0]     in_mag_a, in_mag_b;
  logic [CNT_W-1:0]    cnt_init;
  logic [2*XLEN-1:0]   acc_init, acc_step, prod_fix;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [XLEN-1:0]     quo_fix, rem_fix, fin_value;

  assign accept    = (state_reg == IDLE) && start && !kill;
  assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

  // Operand conditioning: only mulh/mulhsu/div/rem see OP_A as signed, only mulh/div/rem see OP_B as signed.
  assign signed_a = (fun3 == 3'b001) || (fun3 == 3'b010) || (fun3 == 3'b100) || (fun3 == 3'b110);
  assign signed_b = (fun3 == 3'b001) || (fun3 == 3'b100) || (fun3 == 3'b110);
  assign in_neg_a = signed_a && op_a[XLEN-1];
  assign in_neg_b = signed_b && op_b[XLEN-1];
  assign in_mag_a = in_neg_a ? -op_a : op_a;
  assign in_mag_b = in_neg_b ? -op_b : op_b;

`ifdef MULDIV_EARLY_OUT_EN
  logic early_reg;

  assign early_hit = (op_b == '0) || (!fun3[2] && (op_a == '0));
  assign step_en   = !early_reg;

  always_ff @(posedge clk) begin
    if (rst)
      early_reg <= 1'b0;
    else if (accept)
      early_reg <= early_hit;
  end

  // A trivial op spends one frozen CALC cycle; the preload already holds the final magnitudes.
  always_comb begin
    cnt_init = early_hit ? CNT_W'(XLEN - 1) : '0;
    if (early_hit)
      acc_init = fun3[2] ? {in_mag_a, {XLEN{1'b1}}} : '0;
    else
      acc_init = fun3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
  end
`else
  assign early_hit = 1'b0;
  assign step_en   = 1'b1;
  assign cnt_init  = '0;
  assign acc_init  = fun3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
`endif

  // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {partial remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mag_a_reg} : '0);
  assign div_trial = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, mag_b_reg};

  always_comb begin
    acc_step = {mul_sum, acc_reg[XLEN-1:1]};
    if (fun3_reg[2]) begin
      if (div_trial[XLEN])
        acc_step = {acc_reg[2*XLEN-2:0], 1'b0};
      else
        acc_step = {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and output selection in FIN.
  always_comb begin
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    if (b_zero_reg)
      quo_fix = '1;
    else
      quo_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix = neg_a_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (fun3_reg)
      3'b000:                 fin_value = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_value = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_value = quo_fix;
      default:                fin_value = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_iter) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill)
      state_next = IDLE;
  end

  always_comb begin
    busy   = (state_reg != IDLE);
    done   = (state_reg == FIN) && !kill;
    result = done ? fin_value : result_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fun3_reg   <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        fun3_reg   <= fun3;
        mag_a_reg  <= in_mag_a;
        mag_b_reg  <= in_mag_b;
        neg_a_reg  <= in_neg_a;
        neg_b_reg  <= in_neg_b;
        b_zero_reg <= (op_b == '0);
        cnt_reg    <= cnt_init;
        acc_reg    <= acc_init;
      end else if (state_reg == CALC) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (step_en)
          acc_reg <= acc_step;
      end
      if (done)
        result_reg <= fin_value;
    end
  end

endmodule
